bp_be_late_wb_arbiter: RTL
==========================

// Module: bp_be_late_wb_arbiter
//
// PURPOSE
//  Collects late (long-latency) writebacks from several BE producers, e.g. FP divider/sqrt,
//  integer divider and dcache miss/PTW return, and funnels them into the scheduler's single
//  late writeback port.
//  - Per-source buffering; round-robin grant.
//  - Escalates to late_wb_force_o when the scheduler starves the winning writeback for too
//    long, which preempts issue.
//  - Sits between the long-latency pipes and bp_be_scheduler.
//
// PARAMETERS
//  bp_params_p     e_bp_default_cfg  processor config; wb_pkt_width_lp = `bp_be_wb_pkt_width(vaddr_width_p)
//  num_src_p       3                 number of late writeback producers (>=1)
//  els_p           2                 per-source buffer depth (>=1)
//  starve_limit_p  16                stalled cycles tolerated before force is asserted (>=0)
//
// PORTS
//  clk_i            in   1                          clock
//  reset_i          in   1                          asynchronous, active-high reset
//  src_pkt_i        in   num_src_p*wb_pkt_width_lp  bp_be_wb_pkt_s per source; source i at slice i
//  src_v_i          in   num_src_p                  source i offers a packet
//  src_ready_and_o  out  num_src_p                  source i buffer not full; enqueue = v & ready
//  late_wb_pkt_o    out  wb_pkt_width_lp            granted packet
//  late_wb_v_o      out  1                          granted packet valid
//  late_wb_force_o  out  1                          starvation escalation; scheduler must take pkt
//  late_wb_yumi_i   in   1                          scheduler consumes packet this cycle
//
// BEHAVIOUR
//  - Reset (async, immediate): all buffers empty; rr pointer=0; lock=0; starve cnt=0.
//    late_wb_v_o=0, late_wb_force_o=0, late_wb_pkt_o=0, src_ready_and_o=all 1.
//  - Buffers: per-source FIFO of els_p entries, registered.
//    - src_ready_and_o[i] = ~full[i], from registered state only; no comb path from yumi.
//    - A packet enqueued in cycle N is eligible for grant in N+1.
//    - Enqueue and dequeue of the same buffer in one cycle are both legal. Count is unchanged
//      and order is FIFO.
//  - Grant, state IDLE/LOCKED:
//    - IDLE: winner = first non-empty source at or after rr pointer, wrapping modulo num_src_p.
//      late_wb_v_o = any non-empty; pkt = head of winner.
//    - If v_o & ~yumi_i: go LOCKED, latch winner index. Output stays on that source until yumi.
//      Later enqueues never change pkt/v_o (valid-stable rule).
//    - On yumi_i (from either state): pop winner head; rr pointer <= (winner+1) mod num_src_p;
//      go IDLE.
//    - yumi_i while late_wb_v_o=0 is illegal; assert in sim, ignore in RTL.
//    - Throughput: 1 packet/cycle aggregate when yumi_i is held high.
//  - Starvation: cnt width $clog2(starve_limit_p+1), saturating.
//    - cnt <= 0 on yumi_i or ~late_wb_v_o; else cnt+1 (saturate).
//    - late_wb_force_o = late_wb_v_o & (cnt >= starve_limit_p).
//    - starve_limit_p=0 means force is always asserted with valid.
//    - Force is never asserted without valid.
//  - Reset mid-stall or mid-transfer: all in-flight packets are discarded; no partial output.
//
// CONFIGURATION
//  BP_BE_LATE_WB_FIXED_PRIO_EN
//    defined:   fixed priority, lowest non-empty index wins; rr pointer removed. Lock and
//               starvation logic unchanged.
//    undefined: round-robin as above (default).
//
// TESTING
//  1. Src0 enq pkt rd_addr=5 cycle 0, yumi_i=1 -> v_o=1 rd_addr=5 in cycle 1; v_o=0 cycle 2.
//  2. Src0,1,2 enq same cycle, yumi_i held 1 -> grants src0,src1,src2 in consecutive cycles.
//     Next src1-only winner proves rr pointer update.
//  3. Single pkt, yumi_i=0, starve_limit_p=16 -> force_o=0 for 16 cycles, =1 from 17th valid
//     cycle, pkt unchanged; yumi_i -> force_o=0 next cycle.
//  4. Src2 presenting and stalled; src0 enqueues -> output remains src2 until yumi_i;
//     then src0 granted.
//  5. els_p=2, yumi_i=0, src1 enqueues 2 -> src_ready_and_o[1]=0; one yumi on src1 ->
//     ready=1 next cycle.
//  6. Assert reset_i during stall with 3 buffered pkts -> v_o/force_o=0 same cycle,
//     ready all 1, no pkt emitted after release.
//  Macro build: src0 and src1 refilled every cycle -> src0 always wins; src1 only wins
//  when src0 is empty.

Source files
------------

// File: rtl/bp_be_late_wb_arbiter.sv
// Late writeback arbiter: per-producer FIFOs feeding the scheduler's single late writeback port,
// with grant lock until consumed and starvation force. Define BP_BE_LATE_WB_FIXED_PRIO_EN for fixed priority.
module bp_be_late_wb_arbiter #(
  parameter int num_src_p      = 3,
  parameter int els_p          = 2,
  parameter int starve_limit_p = 16,
  parameter int wb_pkt_width_p = 64
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_src_p*wb_pkt_width_p-1:0] src_pkt_i,
  input  logic [num_src_p-1:0]                src_v_i,
  output logic [num_src_p-1:0]                src_ready_and_o,
  output logic [wb_pkt_width_p-1:0]           late_wb_pkt_o,
  output logic                                late_wb_v_o,
  output logic                                late_wb_force_o,
  input  logic                                late_wb_yumi_i
);

  localparam int idx_w_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;
  localparam int sum_w_lp = idx_w_lp + 1;
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam int sc_w_lp  = (starve_limit_p > 0) ? $clog2(starve_limit_p + 1) : 1;
  localparam logic [sc_w_lp-1:0] starve_max_lp = sc_w_lp'(starve_limit_p);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  logic [num_src_p-1:0][wb_pkt_width_p-1:0] w_head;
  logic [num_src_p-1:0]                     w_nonempty;
  logic [num_src_p-1:0]                     w_pop;
  logic [idx_w_lp-1:0]                      w_sel;
  logic [idx_w_lp-1:0]                      w_win;
  logic                                     w_take;
  logic                                     w_starved;

  state_t              r_state;
  logic [idx_w_lp-1:0] r_lock_idx;
  logic [sc_w_lp-1:0]  r_starve_cnt;

  for (genvar gi = 0; gi < num_src_p; gi++) begin : g_src
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

    logic [wb_pkt_width_p-1:0] r_mem [els_p];
    logic [ptr_w_lp-1:0]       r_rptr;
    logic [ptr_w_lp-1:0]       r_wptr;
    logic [cnt_w_lp-1:0]       r_cnt;
    logic                      w_enq;

    // Ready looks only at the stored count, so it never depends on yumi.
    assign src_ready_and_o[gi] = (r_cnt != full_cnt_lp);
    assign w_enq               = src_v_i[gi] & src_ready_and_o[gi];
    assign w_pop[gi]           = w_take & (w_win == idx_w_lp'(gi));
    assign w_nonempty[gi]      = (r_cnt != '0);
    assign w_head[gi]          = r_mem[r_rptr];

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_rptr <= '0;
        r_wptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_enq) begin
          r_wptr <= (r_wptr == last_ptr_lp) ? '0 : r_wptr + 1'b1;
        end
        if (w_pop[gi]) begin
          r_rptr <= (r_rptr == last_ptr_lp) ? '0 : r_rptr + 1'b1;
        end
        if (w_enq & ~w_pop[gi]) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (~w_enq & w_pop[gi]) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (w_enq) begin
        r_mem[r_wptr] <= src_pkt_i[gi*wb_pkt_width_p +: wb_pkt_width_p];
      end
    end
  end

`ifdef BP_BE_LATE_WB_FIXED_PRIO_EN
  always_comb begin
    w_sel = '0;
    for (int k = num_src_p - 1; k >= 0; k--) begin
      if (w_nonempty[k]) begin
        w_sel = idx_w_lp'(k);
      end
    end
  end
`else
  logic [idx_w_lp-1:0]    r_rr;
  logic [2*num_src_p-1:0] w_rot;
  logic [sum_w_lp-1:0]    w_sum;
  logic [sum_w_lp-1:0]    w_win_inc;

  // Rotate so bit k of w_rot is source (rr + k) mod num_src_p; the lowest set k wins.
  assign w_rot     = {w_nonempty, w_nonempty} >> r_rr;
  assign w_win_inc = {1'b0, w_win} + 1'b1;

  always_comb begin
    w_sel = '0;
    w_sum = '0;
    for (int k = num_src_p - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr} + sum_w_lp'(k);
      if (w_sum >= sum_w_lp'(num_src_p)) begin
        w_sum = w_sum - sum_w_lp'(num_src_p);
      end
      if (w_rot[k]) begin
        w_sel = w_sum[idx_w_lp-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rr <= '0;
    end else if (w_take) begin
      r_rr <= (w_win_inc == sum_w_lp'(num_src_p)) ? '0 : w_win_inc[idx_w_lp-1:0];
    end
  end
`endif

  assign late_wb_v_o   = (r_state == ST_LOCKED) | (|w_nonempty);
  assign w_win         = (r_state == ST_LOCKED) ? r_lock_idx : w_sel;
  assign w_take        = late_wb_yumi_i & late_wb_v_o;
  assign late_wb_pkt_o = late_wb_v_o ? w_head[w_win] : '0;

  // Once presented and refused, the winner is held so the packet stays stable until taken.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      r_lock_idx <= '0;
    end else if (w_take) begin
      r_state <= ST_IDLE;
    end else if (late_wb_v_o) begin
      r_state    <= ST_LOCKED;
      r_lock_idx <= w_win;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_starve_cnt <= '0;
    end else if (w_take | ~late_wb_v_o) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != starve_max_lp) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  if (starve_limit_p == 0) begin : g_force_always
    assign w_starved = 1'b1;
  end else begin : g_force_cnt
    assign w_starved = (r_starve_cnt >= starve_max_lp);
  end

  assign late_wb_force_o = late_wb_v_o & w_starved;

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    late_wb_yumi_i |-> late_wb_v_o);

endmodule
